// File: rtl/frog_game_ctrl.sv
// rtl/frog_game_ctrl.sv - frog game state controller: hit/goal detection, lives, level, hold timing
// Optional score register enabled by defining FROG_SCORE_EN (o_score tied to 0 otherwise).
module frog_game_ctrl #(
  parameter int          NUM_LANES      = 4,
  parameter int          LANE_ROW_BASE  = 2,
  parameter int          GOAL_ROW       = 0,
  parameter int          START_LIVES    = 3,
  parameter logic [23:0] HOLD_CYCLES    = 24'd12_500_000,
  parameter int          MAX_LEVEL      = 15,
  parameter bit          CHECK_GOAL_ROW = 1'b1
) (
  input  logic                     i_Clk,
  input  logic                     i_Rst_L,
  input  logic                     i_start,
  input  logic [4:0]               i_frog_x,
  input  logic [3:0]               i_frog_y,
  input  logic [5*NUM_LANES-1:0]   i_car_x,
  output logic [3:0]               o_level,
  output logic [1:0]               o_lives,
  output logic [2:0]               o_state,
  output logic                     o_frog_reset,
  output logic                     o_hit,
  output logic                     o_game_over,
  output logic [7:0]               o_score
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PLAY = 3'd1,
    S_HIT  = 3'd2,
    S_WIN  = 3'd3,
    S_OVER = 3'd4
  } state_t;

  localparam logic [3:0]  LEVEL_MAX  = 4'(MAX_LEVEL);
  localparam logic [1:0]  LIVES_INIT = 2'(START_LIVES);
  localparam logic [23:0] HOLD_LOAD  = HOLD_CYCLES - 24'd1;
  localparam logic [3:0]  GOAL_Y     = 4'(GOAL_ROW);

  // A goal row inside the lane band makes hit and goal ambiguous; reject it at elaboration.
  generate
    if (CHECK_GOAL_ROW && (GOAL_ROW >= LANE_ROW_BASE) && (GOAL_ROW < LANE_ROW_BASE + NUM_LANES)) begin : g_goal_row_check
      $error("frog_game_ctrl: GOAL_ROW lies inside the lane rows");
    end
  endgenerate

  state_t      state_q, state_d;
  logic [3:0]  level_q, level_d;
  logic [1:0]  lives_q, lives_d;
  logic [23:0] hold_q, hold_d;
  logic        frog_reset_q, frog_reset_d;
  logic        hit_q, over_q;
  logic        collide, goal;

  // Frog coincides with the car of the lane it is standing in.
  always_comb begin
    collide = 1'b0;
    for (int k = 0; k < NUM_LANES; k++) begin
      if ((i_frog_y == 4'(LANE_ROW_BASE + k)) && (i_frog_x == i_car_x[5*k +: 5])) begin
        collide = 1'b1;
      end
    end
  end

  assign goal = (i_frog_y == GOAL_Y);

  // Next-state, lives/level update and hold countdown.
  always_comb begin
    state_d      = state_q;
    level_d      = level_q;
    lives_d      = lives_q;
    hold_d       = hold_q;
    frog_reset_d = 1'b0;
    case (state_q)
      S_IDLE, S_OVER: begin
        if (i_start) begin
          state_d      = S_PLAY;
          level_d      = 4'd1;
          lives_d      = LIVES_INIT;
          frog_reset_d = 1'b1;
        end
      end
      S_PLAY: begin
        if (collide) begin
          state_d = S_HIT;
          lives_d = lives_q - 2'd1;
          hold_d  = HOLD_LOAD;
        end else if (goal) begin
          state_d = S_WIN;
          level_d = (level_q >= LEVEL_MAX) ? LEVEL_MAX : level_q + 4'd1;
          hold_d  = HOLD_LOAD;
        end
      end
      S_HIT, S_WIN: begin
        if (hold_q == 24'd0) begin
          if ((state_q == S_HIT) && (lives_q == 2'd0)) begin
            state_d = S_OVER;
          end else begin
            state_d      = S_PLAY;
            frog_reset_d = 1'b1;
          end
        end else begin
          hold_d = hold_q - 24'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs; o_hit/o_game_over follow the next state so they line up with o_state.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q      <= S_IDLE;
      level_q      <= 4'd1;
      lives_q      <= LIVES_INIT;
      hold_q       <= 24'd0;
      frog_reset_q <= 1'b0;
      hit_q        <= 1'b0;
      over_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      lives_q      <= lives_d;
      hold_q       <= hold_d;
      frog_reset_q <= frog_reset_d;
      hit_q        <= (state_d == S_HIT);
      over_q       <= (state_d == S_OVER);
    end
  end

`ifdef FROG_SCORE_EN
  logic [7:0] score_q;
  logic [8:0] score_sum;
  logic       game_start;
  logic       win_entry;

  assign score_sum  = {1'b0, score_q} + {5'd0, level_q};
  assign game_start = ((state_q == S_IDLE) || (state_q == S_OVER)) && i_start;
  assign win_entry  = (state_q == S_PLAY) && (state_d == S_WIN);

  // Score accumulates the pre-increment level on every win, saturating at 255.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      score_q <= 8'd0;
    end else if (game_start) begin
      score_q <= 8'd0;
    end else if (win_entry) begin
      score_q <= score_sum[8] ? 8'hFF : score_sum[7:0];
    end
  end

  assign o_score = score_q;
`else
  assign o_score = 8'd0;
`endif

  assign o_state      = state_q;
  assign o_level      = level_q;
  assign o_lives      = lives_q;
  assign o_frog_reset = frog_reset_q;
  assign o_hit        = hit_q;
  assign o_game_over  = over_q;

endmodule
